// File: rtl/onchip_ram_arb_pkg.sv
// Shared constants and types for the on-chip RAM arbiter.
package onchip_ram_arb_pkg;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int MEM_WORDS = 10240;
  localparam int WAIT_W    = 4;

  typedef enum logic {
    M_CPU   = 1'b0,
    M_AUDIO = 1'b1
  } master_id_t;

  // True when the word address maps onto an implemented RAM word.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return ({{(32-ADDR_W){1'b0}}, addr} < MEM_WORDS);
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Grant selection between the CPU (m0) and the audio fetcher (m1).
// Audio wins by default; the CPU overrides once it has been stalled
// MAX_WAIT consecutive cycles, which bounds its worst-case latency.
module ram_arb_pick
  import onchip_ram_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic grant0,
  output logic grant1
);

  logic [WAIT_W-1:0] wait_cnt;
  logic              starved;

  assign starved = (wait_cnt >= WAIT_W'(MAX_WAIT));

  // Pick at most one master per cycle; nothing is granted until the RAM clock is enabled.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (en) begin
      if (req1 && !(req0 && starved)) begin
        grant1 = 1'b1;
      end else if (req0) begin
        grant0 = 1'b1;
      end
    end
  end

  // Count consecutive cycles in which the CPU waits, saturating at the counter limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (req0 && !grant0) begin
      if (wait_cnt != {WAIT_W{1'b1}}) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Two-master arbiter in front of the single-port program/data RAM.
// Holds the request mux, the out-of-range check and the read-return pipeline.
module onchip_ram_arbiter
  import onchip_ram_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,

  output logic              oor_err
);

  logic              req0, req1;
  logic              grant0, grant1, grant_any;
  logic              en;
  logic [ADDR_W-1:0] sel_address;
  logic [BE_W-1:0]   sel_byteenable;
  logic [DATA_W-1:0] sel_writedata;
  logic              sel_read, sel_write;
  logic              sel_oor;
  logic              rd_accept;
  logic              rd_pend;
  master_id_t        rd_owner;
  logic              rd_oor;
  logic [DATA_W-1:0] ret_data;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign en        = ram_clken & reset_n;
  assign grant_any = grant0 | grant1;

  ram_arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .req0    (req0),
    .req1    (req1),
    .grant0  (grant0),
    .grant1  (grant1)
  );

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  // Route the granted master's command onto the RAM port (m0 when idle).
  always_comb begin
    sel_address    = m0_address;
    sel_byteenable = m0_byteenable;
    sel_writedata  = m0_writedata;
    sel_read       = m0_read;
    sel_write      = m0_write;
    if (grant1) begin
      sel_address    = m1_address;
      sel_byteenable = m1_byteenable;
      sel_writedata  = m1_writedata;
      sel_read       = m1_read;
      sel_write      = m1_write;
    end
  end

  // Read+write together is handled as a write, so only a pure read enters the return pipe.
  assign sel_oor        = ~addr_in_range(sel_address);
  assign rd_accept      = grant_any & sel_read & ~sel_write;
  assign ram_address    = sel_address;
  assign ram_byteenable = sel_byteenable;
  assign ram_writedata  = sel_writedata;
  assign ram_chipselect = grant_any;
  assign ram_write      = grant_any & sel_write & ~sel_oor;

  // Track the in-flight read, raise the error pulse and enable the RAM clock after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_clken <= 1'b0;
      oor_err   <= 1'b0;
      rd_pend   <= 1'b0;
      rd_owner  <= M_CPU;
      rd_oor    <= 1'b0;
    end else begin
      ram_clken <= 1'b1;
      oor_err   <= grant_any & (sel_oor | (sel_read & sel_write));
      rd_pend   <= rd_accept;
      if (rd_accept) begin
        rd_owner <= grant1 ? M_AUDIO : M_CPU;
        rd_oor   <= sel_oor;
      end
    end
  end

  assign ret_data         = rd_oor ? '0 : ram_readdata;
  assign m0_readdatavalid = rd_pend & (rd_owner == M_CPU);
  assign m1_readdatavalid = rd_pend & (rd_owner == M_AUDIO);
  assign m0_readdata      = m0_readdatavalid ? ret_data : '0;
  assign m1_readdata      = m1_readdatavalid ? ret_data : '0;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Self-checking bench for onchip_ram_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_onchip_ram_arbiter;
  import onchip_ram_arb_pkg::*;

  localparam int MAXW = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic [BE_W-1:0]   m0_byteenable = '0, m1_byteenable = '0;
  logic              m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic              ram_chipselect, ram_write, ram_clken, oor_err;
  logic [DATA_W-1:0] ram_writedata;
  logic [DATA_W-1:0] ram_readdata;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit          run = 0;
  int          stall = 0;
  bit          pend_v0 = 0, pend_v1 = 0, pend_oor = 0;
  logic [31:0] pend_d0 = '0, pend_d1 = '0;
  logic [31:0] ref_mem [int];

  // per-cycle expected and observed snapshots
  logic        exp_wait0, exp_wait1, exp_ramwr, exp_rdv0, exp_rdv1, exp_oor;
  logic [31:0] exp_rd0, exp_rd1;
  logic        obs_wait0 = 0, obs_wait1 = 0, obs_ramwr, obs_rdv0, obs_rdv1, obs_oor, obs_clken;
  logic [31:0] obs_rd0, obs_rd1;

  onchip_ram_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata),
    .oor_err          (oor_err)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency; unmapped reads return junk.
  logic [31:0] ram_mem [0:MEM_WORDS-1];
  initial for (int i = 0; i < MEM_WORDS; i++) ram_mem[i] = 32'h0;
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] = ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= (int'(ram_address) < MEM_WORDS) ? ram_mem[ram_address] : 32'hBAD0_BAD0;
      end
    end
  end

  function automatic logic [31:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic set_m0(input logic rd, input logic wr, input int a, input logic [3:0] be, input logic [31:0] d);
    m0_read = rd; m0_write = wr; m0_address = ADDR_W'(a); m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic set_m1(input logic rd, input logic wr, input int a, input logic [3:0] be, input logic [31:0] d);
    m1_read = rd; m1_write = wr; m1_address = ADDR_W'(a); m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic idle();
    set_m0(0, 0, 0, 4'h0, 32'h0);
    set_m1(0, 0, 0, 4'h0, 32'h0);
  endtask

  // Effect of one accepted transaction on the reference memory and the return queue.
  task automatic model_access(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                              input logic [3:0] be, input logic [31:0] d, input int who);
    int          a;
    bit          oor;
    logic [31:0] w;
    a   = int'(addr);
    oor = (a >= MEM_WORDS);
    if (wr) begin
      if (!oor) begin
        w = ref_read(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[a] = w;
        exp_ramwr  = 1'b1;
      end
      pend_oor = oor || rd;
    end else begin
      pend_oor = oor;
      if (who == 0) begin pend_v0 = 1; pend_d0 = oor ? 32'h0 : ref_read(a); end
      else          begin pend_v1 = 1; pend_d1 = oor ? 32'h0 : ref_read(a); end
    end
  endtask

  // One bus cycle: snapshot DUT outputs, predict expectations, advance past the clock edge.
  task automatic cycle();
    bit r0, r1, g0, g1;
    #1;
    if (!reset_n) begin
      pend_v0 = 0; pend_v1 = 0; pend_oor = 0; stall = 0; run = 0;
    end
    exp_rdv0 = pend_v0; exp_rd0 = pend_v0 ? pend_d0 : 32'h0;
    exp_rdv1 = pend_v1; exp_rd1 = pend_v1 ? pend_d1 : 32'h0;
    exp_oor  = pend_oor;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    g0 = run && reset_n && r0 && (!r1 || stall >= MAXW);
    g1 = run && reset_n && r1 && !g0;
    exp_wait0 = r0 && !g0;
    exp_wait1 = r1 && !g1;
    obs_wait0 = m0_waitrequest;  obs_wait1 = m1_waitrequest;
    obs_rdv0  = m0_readdatavalid; obs_rdv1 = m1_readdatavalid;
    obs_rd0   = m0_readdata;     obs_rd1   = m1_readdata;
    obs_ramwr = ram_write;       obs_oor   = oor_err;  obs_clken = ram_clken;
    pend_v0 = 0; pend_v1 = 0; pend_oor = 0; exp_ramwr = 0;
    if (g0) model_access(m0_read, m0_write, m0_address, m0_byteenable, m0_writedata, 0);
    if (g1) model_access(m1_read, m1_write, m1_address, m1_byteenable, m1_writedata, 1);
    if (reset_n && r0 && !g0) stall = (stall < 15) ? stall + 1 : 15;
    else stall = 0;
    run = reset_n;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle();
    set_m0(1, 0, 5, 4'hF, 32'h0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++; if (obs_wait0 !== 1'b1) $display("[TB] FAIL reset_wait0 got %b want 1", obs_wait0); else n_pass++;
      n_checks++; if (obs_clken !== 1'b0) $display("[TB] FAIL reset_clken got %b want 0", obs_clken); else n_pass++;
      n_checks++; if (obs_rdv0 !== 1'b0 || obs_oor !== 1'b0) $display("[TB] FAIL reset_outs got rdv0=%b oor=%b want 0 0", obs_rdv0, obs_oor); else n_pass++;
    end
    reset_n = 1;
    cycle();
    n_checks++; if (obs_wait0 !== 1'b1) $display("[TB] FAIL release_wait0 got %b want 1", obs_wait0); else n_pass++;
    cycle();
    n_checks++; if (obs_clken !== 1'b1) $display("[TB] FAIL release_clken got %b want 1", obs_clken); else n_pass++;
    n_checks++; if (obs_wait0 !== 1'b0) $display("[TB] FAIL first_grant_wait0 got %b want 0", obs_wait0); else n_pass++;
    idle();
    cycle();
    n_checks++; if (obs_rdv0 !== 1'b1 || obs_rd0 !== 32'h0) $display("[TB] FAIL first_read got v=%b d=%h want 1 00000000", obs_rdv0, obs_rd0); else n_pass++;
  endtask

  task automatic test_single_write();
    set_m1(0, 1, 32'h10, 4'hF, 32'hA5A5_1234);
    cycle();
    n_checks++; if (obs_wait1 !== 1'b0 || obs_ramwr !== 1'b1) $display("[TB] FAIL single_write got wait=%b wr=%b want 0 1", obs_wait1, obs_ramwr); else n_pass++;
    set_m1(1, 0, 32'h10, 4'hF, 32'h0);
    cycle();
    n_checks++; if (obs_wait1 !== 1'b0 || obs_ramwr !== 1'b0) $display("[TB] FAIL single_read_issue got wait=%b wr=%b want 0 0", obs_wait1, obs_ramwr); else n_pass++;
    idle();
    cycle();
    n_checks++; if (obs_rdv1 !== 1'b1 || obs_rd1 !== 32'hA5A5_1234) $display("[TB] FAIL single_readback got v=%b d=%h want 1 a5a51234", obs_rdv1, obs_rd1); else n_pass++;
    n_checks++; if (obs_rdv0 !== 1'b0 || obs_rd0 !== 32'h0) $display("[TB] FAIL other_master_quiet got v=%b d=%h want 0 00000000", obs_rdv0, obs_rd0); else n_pass++;
  endtask

  task automatic test_byte_lanes();
    set_m0(0, 1, 32'h20, 4'hF, 32'hFFFF_FFFF); cycle();
    set_m0(0, 1, 32'h20, 4'h2, 32'h0000_0000); cycle();
    set_m0(1, 0, 32'h20, 4'hF, 32'h0);         cycle();
    idle();
    cycle();
    n_checks++; if (obs_rdv0 !== 1'b1 || obs_rd0 !== 32'hFFFF_00FF) $display("[TB] FAIL byte_lanes got v=%b d=%h want 1 ffff00ff", obs_rdv0, obs_rd0); else n_pass++;
  endtask

  task automatic test_starvation();
    int a0 = 32'h40, a1 = 32'h10;
    idle();
    cycle();
    for (int i = 0; i < 10; i++) begin
      set_m1(1, 0, a1, 4'hF, 32'h0);
      set_m0(1, 0, a0, 4'hF, 32'h0);
      cycle();
      n_checks++; if (obs_wait0 !== (i % 5 != 4)) $display("[TB] FAIL starve_wait0[%0d] got %b want %b", i, obs_wait0, (i % 5 != 4)); else n_pass++;
      n_checks++; if (obs_wait1 !== (i % 5 == 4)) $display("[TB] FAIL starve_wait1[%0d] got %b want %b", i, obs_wait1, (i % 5 == 4)); else n_pass++;
      n_checks++; if (obs_rdv1 !== exp_rdv1 || obs_rd1 !== exp_rd1) $display("[TB] FAIL starve_data1[%0d] got %b/%h want %b/%h", i, obs_rdv1, obs_rd1, exp_rdv1, exp_rd1); else n_pass++;
      if (i % 5 == 4) a0++; else a1++;
    end
    idle();
    cycle();
    n_checks++; if (obs_rdv0 !== 1'b1 || obs_rd0 !== exp_rd0) $display("[TB] FAIL starve_data0 got %b/%h want 1/%h", obs_rdv0, obs_rd0, exp_rd0); else n_pass++;
  endtask

  task automatic test_out_of_range();
    set_m0(0, 1, 10239, 4'hF, 32'h1234_5678); cycle();
    n_checks++; if (obs_ramwr !== 1'b1) $display("[TB] FAIL last_word_write got %b want 1", obs_ramwr); else n_pass++;
    set_m0(0, 1, 10240, 4'hF, 32'hDEAD_BEEF); cycle();
    n_checks++; if (obs_ramwr !== 1'b0 || obs_wait0 !== 1'b0) $display("[TB] FAIL oor_write got wr=%b wait=%b want 0 0", obs_ramwr, obs_wait0); else n_pass++;
    n_checks++; if (obs_oor !== 1'b0) $display("[TB] FAIL oor_quiet got %b want 0", obs_oor); else n_pass++;
    set_m0(1, 0, 10240, 4'hF, 32'h0); cycle();
    n_checks++; if (obs_oor !== 1'b1 || obs_ramwr !== 1'b0) $display("[TB] FAIL oor_pulse1 got oor=%b wr=%b want 1 0", obs_oor, obs_ramwr); else n_pass++;
    set_m0(1, 0, 10239, 4'hF, 32'h0); cycle();
    n_checks++; if (obs_oor !== 1'b1) $display("[TB] FAIL oor_pulse2 got %b want 1", obs_oor); else n_pass++;
    n_checks++; if (obs_rdv0 !== 1'b1 || obs_rd0 !== 32'h0) $display("[TB] FAIL oor_read got v=%b d=%h want 1 00000000", obs_rdv0, obs_rd0); else n_pass++;
    idle();
    set_m1(1, 1, 32'h30, 4'hF, 32'h0BAD_F00D); cycle();
    n_checks++; if (obs_oor !== 1'b0) $display("[TB] FAIL last_word_oor got %b want 0", obs_oor); else n_pass++;
    n_checks++; if (obs_rdv0 !== 1'b1 || obs_rd0 !== 32'h1234_5678) $display("[TB] FAIL last_word_read got v=%b d=%h want 1 12345678", obs_rdv0, obs_rd0); else n_pass++;
    n_checks++; if (obs_ramwr !== 1'b1) $display("[TB] FAIL rw_as_write got %b want 1", obs_ramwr); else n_pass++;
    idle(); cycle();
    n_checks++; if (obs_oor !== 1'b1 || obs_rdv1 !== 1'b0) $display("[TB] FAIL rw_flag got oor=%b rdv1=%b want 1 0", obs_oor, obs_rdv1); else n_pass++;
    cycle();
    n_checks++; if (obs_oor !== 1'b0) $display("[TB] FAIL oor_single_cycle got %b want 0", obs_oor); else n_pass++;
  endtask

  task automatic test_mid_read_reset();
    idle();
    set_m0(1, 0, 32'h10, 4'hF, 32'h0); cycle();
    n_checks++; if (obs_wait0 !== 1'b0) $display("[TB] FAIL midrst_accept got %b want 0", obs_wait0); else n_pass++;
    reset_n = 0; cycle();
    n_checks++; if (obs_rdv0 !== 1'b0 || obs_rd0 !== 32'h0) $display("[TB] FAIL midrst_drop got v=%b d=%h want 0 00000000", obs_rdv0, obs_rd0); else n_pass++;
    n_checks++; if (obs_clken !== 1'b0 || obs_oor !== 1'b0 || obs_wait0 !== 1'b1) $display("[TB] FAIL midrst_regs got clken=%b oor=%b wait=%b want 0 0 1", obs_clken, obs_oor, obs_wait0); else n_pass++;
    reset_n = 1; cycle();
    n_checks++; if (obs_wait0 !== 1'b1 || obs_rdv0 !== 1'b0) $display("[TB] FAIL midrst_release got wait=%b v=%b want 1 0", obs_wait0, obs_rdv0); else n_pass++;
    cycle();
    n_checks++; if (obs_wait0 !== 1'b0) $display("[TB] FAIL midrst_regrant got %b want 0", obs_wait0); else n_pass++;
    idle(); cycle();
    n_checks++; if (obs_rdv0 !== 1'b1 || obs_rd0 !== 32'hA5A5_1234) $display("[TB] FAIL midrst_reread got v=%b d=%h want 1 a5a51234", obs_rdv0, obs_rd0); else n_pass++;
  endtask

  task automatic rand_op(input int who);
    int          op, a;
    logic [3:0]  be;
    logic [31:0] d;
    op = int'($urandom_range(0, 9));
    a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10236, 10243)) : int'($urandom_range(0, 31));
    be = 4'($urandom_range(0, 15));
    d  = $urandom;
    if (who == 0) set_m0(op >= 4 && op < 7, op >= 7, a, be, d);
    else          set_m1(op >= 4 && op < 7, op >= 7, a, be, d);
  endtask

  task automatic test_random();
    idle();
    obs_wait0 = 0;
    obs_wait1 = 0;
    for (int n = 0; n < 400; n++) begin
      if (obs_wait0 !== 1'b1) rand_op(0);
      if (obs_wait1 !== 1'b1) rand_op(1);
      cycle();
      n_checks++; if (obs_wait0 !== exp_wait0) $display("[TB] FAIL rnd_wait0[%0d] got %b want %b", n, obs_wait0, exp_wait0); else n_pass++;
      n_checks++; if (obs_wait1 !== exp_wait1) $display("[TB] FAIL rnd_wait1[%0d] got %b want %b", n, obs_wait1, exp_wait1); else n_pass++;
      n_checks++; if (obs_ramwr !== exp_ramwr) $display("[TB] FAIL rnd_ramwr[%0d] got %b want %b", n, obs_ramwr, exp_ramwr); else n_pass++;
      n_checks++; if (obs_oor !== exp_oor) $display("[TB] FAIL rnd_oor[%0d] got %b want %b", n, obs_oor, exp_oor); else n_pass++;
      n_checks++; if (obs_rdv0 !== exp_rdv0 || obs_rd0 !== exp_rd0) $display("[TB] FAIL rnd_rd0[%0d] got %b/%h want %b/%h", n, obs_rdv0, obs_rd0, exp_rdv0, exp_rd0); else n_pass++;
      n_checks++; if (obs_rdv1 !== exp_rdv1 || obs_rd1 !== exp_rd1) $display("[TB] FAIL rnd_rd1[%0d] got %b/%h want %b/%h", n, obs_rdv1, obs_rd1, exp_rdv1, exp_rd1); else n_pass++;
    end
    idle();
    cycle();
    n_checks++; if (obs_rdv0 !== exp_rdv0 || obs_rdv1 !== exp_rdv1 || obs_rd0 !== exp_rd0 || obs_rd1 !== exp_rd1)
      $display("[TB] FAIL rnd_drain got %b/%h %b/%h want %b/%h %b/%h", obs_rdv0, obs_rd0, obs_rdv1, obs_rd1, exp_rdv0, exp_rd0, exp_rdv1, exp_rd1);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_byte_lanes();
    test_starvation();
    test_out_of_range();
    test_mid_read_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/onchip_ram_arbiter.md
Name: onchip_ram_arbiter

Overview:
- Shares the single-port on-chip program/data RAM (32-bit words, 14-bit word address, 10240 words, byte enables, 1-cycle read latency) between two Avalon-MM requesters.
- m0 is the Nios CPU data port. m1 is the audio sample fetcher, which has priority because the jukebox DAC path must not underrun.
- Issues at most one RAM access per cycle with fully pipelined reads, and enforces a starvation bound for m0.
- Sits between the interconnect and the RAM instance inside the Qsys system.

Parameters:
- ADDR_W, 14, word-address width of both masters and of the RAM.
- DATA_W, 32, data width.
- BE_W, 4, byte-enable width (DATA_W/8).
- MEM_WORDS, 10240, number of implemented words; addresses at or above this value are out of range.
- MAX_WAIT, 4, consecutive stalled cycles after which m0 overrides m1 for one grant (1..15).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- mN_address  in  ADDR_W  word address (N = 0, 1; the same port set exists per master).
- mN_byteenable  in  BE_W  byte lanes.
- mN_read  in  1  read request.
- mN_write  in  1  write request.
- mN_writedata  in  DATA_W  write data.
- mN_waitrequest  out  1  request not accepted this cycle.
- mN_readdata  out  DATA_W  read data.
- mN_readdatavalid  out  1  readdata valid.
- ram_address  out  ADDR_W  RAM address.
- ram_byteenable  out  BE_W  RAM byte enables.
- ram_chipselect  out  1  RAM select.
- ram_write  out  1  RAM write strobe.
- ram_writedata  out  DATA_W  RAM write data.
- ram_clken  out  1  RAM clock enable.
- ram_readdata  in  DATA_W  RAM read data, valid the cycle after a read is issued.
- oor_err  out  1  one-cycle pulse on any accepted out-of-range access.

Behaviour:
- Reset (async assert, sync deassert):
  - Registers: wait_cnt=0, rd_pend=0, rd_owner=0, ram_clken=0, oor_err=0, both mN_readdatavalid=0.
  - ram_clken goes to 1 on the first clk edge after deassertion.
  - While reset_n=0 or ram_clken=0, no grant is given; mN_waitrequest = mN_read|mN_write.
- Request: reqN = mN_read|mN_write. Avalon rule: the master holds all request signals stable while waitrequest=1.
- Grant (combinational from registered wait_cnt):
  - Only m1 requests: grant m1.
  - Only m0 requests: grant m0.
  - Both request: grant m0 if wait_cnt>=MAX_WAIT, else m1.
  - mN_waitrequest = reqN & ~grantN.
- wait_cnt:
  - Increments (saturating at 15) each cycle m0 requests and is not granted.
  - Clears when m0 is granted or m0 is not requesting.
- Issue: the granted master's address, byteenable and writedata drive the ram_* outputs. ram_chipselect=1 while any grant is active. ram_write = granted write & in-range.
- Out-of-range (address >= MEM_WORDS):
  - The access is accepted (waitrequest=0) and ram_write is suppressed.
  - A read returns 0x00000000 with normal latency.
  - oor_err pulses the next cycle.
- Read pipeline:
  - On an accepted read: rd_pend<=1, rd_owner<=N, rd_oor<=out-of-range flag. Otherwise rd_pend<=0.
  - Next cycle: m[rd_owner]_readdatavalid=1, and its readdata = rd_oor ? 0 : ram_readdata.
  - Back-to-back reads from either master are sustained at 1 per cycle. Order per master is preserved by construction.
- Read and write asserted together on one master: treated as a write, and oor_err pulses. This is an illegal stimulus that must be flagged.
- Non-granted mN_readdata is held at 0.
- Writes produce no readdatavalid. A write followed by a read to the same address in the next cycle returns the new data.
- Reset mid-read: the pending readdatavalid is dropped, and no data is returned after reset.

Decomposition:
- Package onchip_ram_arb_pkg:
  - ADDR_W/DATA_W/BE_W/MEM_WORDS constants.
  - Master-id type (M_CPU=0, M_AUDIO=1).
  - Saturating counter width constant WAIT_W=4.
- Sub-module ram_arb_pick: grant logic plus the wait_cnt register. Inputs are req0/req1; outputs are grant0/grant1.
- The top level holds the mux, OOR check and read-return pipeline.

Test Plan:
- Reset with m0_read=1 held → m0_waitrequest=1 until the first cycle after ram_clken=1, then the read is issued; readdatavalid follows 1 cycle later.
- Single write: m1 writes 0xA5A5_1234 to addr 0x0010 with byteenable 0xF, then reads addr 0x0010 → readdatavalid one cycle after the read grant with data 0xA5A51234.
- Byte lanes: write 0xFFFFFFFF with byteenable 0xF, then write 0x00000000 with byteenable 0x2, then read → 0xFFFF00FF.
- Starvation: m1 reads continuously and m0 requests from cycle 0 → m0 is granted on cycle 4 (MAX_WAIT=4), m1 waits exactly that cycle, then the pattern repeats every 5 cycles.
- Out-of-range: m0 writes 0xDEADBEEF to addr 10240 and then reads it back → ram_write stays 0, oor_err pulses twice, and the read returns 0x00000000. A read from addr 10239 is unaffected.
- Mid-read reset: m0 read accepted, reset_n pulsed low before the next edge → m0_readdatavalid stays 0 and all registers return to their reset values.
